udp_rx: RTL and testbench

- Receive-side counterpart of udp_tx.
- Consumes the MAC payload byte stream (MAC header already stripped) and parses and validates the IPv4 and UDP headers.
- Strips both headers and any Ethernet padding, then emits the UDP payload as an 8-bit valid/last stream with per-datagram metadata.
- Rejected datagrams are discarded with a drop pulse and a reason code.

---
 rtl/udp_rx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_udp_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx.sv
// udp_rx: IPv4/UDP receive parser with header validation and payload strip.
// UDP_RX_CHECKSUM_CHECK_EN enables the IPv4 header checksum check.
package eth_pkg;
  localparam int eth_ipv4_header_length = 20;
  localparam int eth_udp_header_length = 8;
  localparam int eth_udp_length_width = 16;
endpackage

module udp_rx
  import eth_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Local_ip_addr,
  input  logic [15:0] Local_udp_port,
  input  logic [7:0]  Mac_payload_data,
  input  logic        Mac_payload_valid,
  input  logic        Mac_payload_last,
  output logic [7:0]  Udp_data,
  output logic        Udp_valid,
  output logic        Udp_last,
  output logic        Udp_error,
  output logic [31:0] Udp_src_ip,
  output logic [15:0] Udp_src_port,
  output logic [eth_udp_length_width-1:0] Udp_length,
  output logic        Drop_valid,
  output logic [2:0]  Drop_reason
);

  localparam int LW = eth_udp_length_width;
  localparam logic [4:0] IP_LAST =
    5'(eth_ipv4_header_length - 1);
  localparam logic [4:0] HDR_LAST =
    5'(eth_ipv4_header_length + eth_udp_header_length - 1);

  typedef enum logic [1:0] {
    S_IP_HDR,
    S_UDP_HDR,
    S_PAYLOAD,
    S_DISCARD
  } state_t;

  state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [LW-1:0] rem_q, rem_d;

  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;
  logic [2:0]    reason_q, reason_d;
  logic [31:0]   mip_q, mip_d;
  logic [15:0]   mport_q, mport_d;
  logic [LW-1:0] mlen_q, mlen_d;

  logic [7:0]    ver_q;
  logic [15:0]   tot_q;
  logic [13:0]   frag_q;
  logic [7:0]    proto_q;
  logic [31:0]   sip_q;
  logic [31:0]   dip_q;
  logic [15:0]   sport_q;
  logic [15:0]   dport_q;
  logic [15:0]   ulen_q;

  logic          in_hdr;
  logic          sum_bad;
  logic [2:0]    reason;

  assign in_hdr = Mac_payload_valid &&
    (state_q == S_IP_HDR || state_q == S_UDP_HDR);

`ifdef UDP_RX_CHECKSUM_CHECK_EN
  logic [31:0] acc_q;
  logic [31:0] word;

  function automatic logic [15:0] fold(input logic [31:0] a);
    logic [16:0] s;
    s = {1'b0, a[15:0]} + {1'b0, a[31:16]};
    return s[15:0] + {15'h0, s[16]};
  endfunction

  assign word = cnt_q[0] ? {24'h0, Mac_payload_data}
                         : {16'h0, Mac_payload_data, 8'h0};

  // One's-complement accumulation over the IP header, folded at its last byte
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q <= '0;
    end else if (Mac_payload_valid && state_q == S_IP_HDR) begin
      if (cnt_q == 5'd0)
        acc_q <= word;
      else if (cnt_q == IP_LAST)
        acc_q <= {16'h0, fold(acc_q + word)};
      else
        acc_q <= acc_q + word;
    end
  end

  assign sum_bad = (acc_q[15:0] != 16'hFFFF);
`else
  assign sum_bad = 1'b0;
`endif

  // Capture header fields by byte position
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ver_q   <= '0;
      tot_q   <= '0;
      frag_q  <= '0;
      proto_q <= '0;
      sip_q   <= '0;
      dip_q   <= '0;
      sport_q <= '0;
      dport_q <= '0;
      ulen_q  <= '0;
    end else if (in_hdr) begin
      case (cnt_q)
        5'd0:  ver_q <= Mac_payload_data;
        5'd2:  tot_q[15:8] <= Mac_payload_data;
        5'd3:  tot_q[7:0] <= Mac_payload_data;
        5'd6:  frag_q[13:8] <= Mac_payload_data[5:0];
        5'd7:  frag_q[7:0] <= Mac_payload_data;
        5'd9:  proto_q <= Mac_payload_data;
        5'd12, 5'd13, 5'd14, 5'd15:
          sip_q <= {sip_q[23:0], Mac_payload_data};
        5'd16, 5'd17, 5'd18, 5'd19:
          dip_q <= {dip_q[23:0], Mac_payload_data};
        5'd20: sport_q[15:8] <= Mac_payload_data;
        5'd21: sport_q[7:0] <= Mac_payload_data;
        5'd22: dport_q[15:8] <= Mac_payload_data;
        5'd23: dport_q[7:0] <= Mac_payload_data;
        5'd24: ulen_q[15:8] <= Mac_payload_data;
        5'd25: ulen_q[7:0] <= Mac_payload_data;
        default: ;
      endcase
    end
  end

  // Lowest failing check wins; 0 means the datagram is accepted
  always_comb begin
    reason = 3'd0;
    if (ver_q != 8'h45)
      reason = 3'd1;
    else if (proto_q != 8'd17)
      reason = 3'd2;
    else if (sum_bad)
      reason = 3'd3;
    else if (frag_q != 14'd0)
      reason = 3'd4;
    else if (dip_q != Local_ip_addr)
      reason = 3'd5;
    else if (dport_q != Local_udp_port)
      reason = 3'd6;
    else if (ulen_q < 16'd9 ||
             ({1'b0, ulen_q} + 17'(eth_ipv4_header_length)
               > {1'b0, tot_q}))
      reason = 3'd7;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    reason_d = 3'd0;
    mip_d    = mip_q;
    mport_d  = mport_q;
    mlen_d   = mlen_q;
    unique case (state_q)
      S_IP_HDR: begin
        if (Mac_payload_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (Mac_payload_last) begin
            drop_d   = 1'b1;
            reason_d = 3'd7;
            cnt_d    = 5'd0;
          end else if (cnt_q == IP_LAST) begin
            state_d = S_UDP_HDR;
          end
        end
      end
      S_UDP_HDR: begin
        if (Mac_payload_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == HDR_LAST) begin
            cnt_d = 5'd0;
            if (reason != 3'd0) begin
              drop_d   = 1'b1;
              reason_d = reason;
              state_d  = Mac_payload_last ? S_IP_HDR : S_DISCARD;
            end else if (Mac_payload_last) begin
              drop_d   = 1'b1;
              reason_d = 3'd7;
              state_d  = S_IP_HDR;
            end else begin
              rem_d   = ulen_q - 16'(eth_udp_header_length);
              mip_d   = sip_q;
              mport_d = sport_q;
              mlen_d  = ulen_q - 16'(eth_udp_header_length);
              state_d = S_PAYLOAD;
            end
          end else if (Mac_payload_last) begin
            drop_d   = 1'b1;
            reason_d = 3'd7;
            cnt_d    = 5'd0;
            state_d  = S_IP_HDR;
          end
        end
      end
      S_PAYLOAD: begin
        if (Mac_payload_valid) begin
          valid_d = 1'b1;
          data_d  = Mac_payload_data;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            last_d  = 1'b1;
            state_d = Mac_payload_last ? S_IP_HDR : S_DISCARD;
          end else if (Mac_payload_last) begin
            last_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IP_HDR;
          end
        end
      end
      S_DISCARD: begin
        if (Mac_payload_valid && Mac_payload_last)
          state_d = S_IP_HDR;
      end
      default: state_d = S_IP_HDR;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IP_HDR;
      cnt_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      reason_q <= '0;
      mip_q    <= '0;
      mport_q  <= '0;
      mlen_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      reason_q <= reason_d;
      mip_q    <= mip_d;
      mport_q  <= mport_d;
      mlen_q   <= mlen_d;
    end
  end

  assign Udp_data     = data_q;
  assign Udp_valid    = valid_q;
  assign Udp_last     = last_q;
  assign Udp_error    = err_q;
  assign Udp_src_ip   = mip_q;
  assign Udp_src_port = mport_q;
  assign Udp_length   = mlen_q;
  assign Drop_valid   = drop_q;
  assign Drop_reason  = reason_q;

endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: directed frames plus a back-to-back random burst for udp_rx.
// Optional checksum expectations follow UDP_RX_CHECKSUM_CHECK_EN.
module tb_udp_rx;

  localparam int LW = eth_pkg::eth_udp_length_width;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [31:0]   Local_ip_addr = 32'h0A00_0002;
  logic [15:0]   Local_udp_port = 16'd5000;
  logic [7:0]    Mac_payload_data;
  logic          Mac_payload_valid;
  logic          Mac_payload_last;
  logic [7:0]    Udp_data;
  logic          Udp_valid;
  logic          Udp_last;
  logic          Udp_error;
  logic [31:0]   Udp_src_ip;
  logic [15:0]   Udp_src_port;
  logic [LW-1:0] Udp_length;
  logic          Drop_valid;
  logic [2:0]    Drop_reason;

  udp_rx dut (
    .Clk(Clk),
    .Rst(Rst),
    .Local_ip_addr(Local_ip_addr),
    .Local_udp_port(Local_udp_port),
    .Mac_payload_data(Mac_payload_data),
    .Mac_payload_valid(Mac_payload_valid),
    .Mac_payload_last(Mac_payload_last),
    .Udp_data(Udp_data),
    .Udp_valid(Udp_valid),
    .Udp_last(Udp_last),
    .Udp_error(Udp_error),
    .Udp_src_ip(Udp_src_ip),
    .Udp_src_port(Udp_src_port),
    .Udp_length(Udp_length),
    .Drop_valid(Drop_valid),
    .Drop_reason(Drop_reason)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fr[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         last_pos[$];
  int         n_err;
  int         n_drop;
  logic [2:0] rsn;

  // Output monitor, sampled mid-cycle
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Udp_valid) begin
        got_q.push_back(Udp_data);
        if (Udp_last) begin
          last_pos.push_back(got_q.size());
          if (Udp_error) n_err++;
        end
      end
      if (Drop_valid) begin
        n_drop++;
        rsn = Drop_reason;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int seed, input int i);
    return 8'(seed + 3 * i);
  endfunction

  task automatic clr();
    got_q.delete();
    last_pos.delete();
    n_err = 0;
    n_drop = 0;
    rsn = 3'd0;
  endtask

  task automatic build(input logic [7:0] ver, input logic [7:0] proto,
                       input logic [15:0] frag, input logic [31:0] dip,
                       input logic [15:0] dport, input logic [15:0] tot,
                       input logic [15:0] ulen, input int npay,
                       input int flen, input logic [7:0] xcs,
                       input int seed);
    logic [7:0]  h[28];
    logic [31:0] s;
    logic [15:0] cs;
    h[0] = ver;  h[1] = 8'h00;
    h[2] = tot[15:8]; h[3] = tot[7:0];
    h[4] = 8'h12; h[5] = 8'h34;
    h[6] = frag[15:8]; h[7] = frag[7:0];
    h[8] = 8'd64; h[9] = proto;
    h[10] = 8'h00; h[11] = 8'h00;
    h[12] = 8'hC0; h[13] = 8'hA8; h[14] = 8'h01; h[15] = 8'h0A;
    h[16] = dip[31:24]; h[17] = dip[23:16];
    h[18] = dip[15:8];  h[19] = dip[7:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'h0, h[2*i], h[2*i+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    h[10] = cs[15:8];
    h[11] = cs[7:0] ^ xcs;
    h[20] = 8'h12; h[21] = 8'h34;
    h[22] = dport[15:8]; h[23] = dport[7:0];
    h[24] = ulen[15:8];  h[25] = ulen[7:0];
    h[26] = 8'h00; h[27] = 8'h00;
    fr.delete();
    for (int i = 0; i < 28; i++) fr.push_back(h[i]);
    for (int i = 0; i < npay; i++) fr.push_back(pay(seed, i));
    while (fr.size() < flen) fr.push_back(8'h00);
  endtask

  task automatic send(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      while ($urandom_range(99) < gap) begin
        @(negedge Clk);
        Mac_payload_valid = 1'b0;
        Mac_payload_last = 1'b0;
      end
      @(negedge Clk);
      Mac_payload_data = fr[i];
      Mac_payload_valid = 1'b1;
      Mac_payload_last = (i == fr.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Mac_payload_valid = 1'b0;
      Mac_payload_last = 1'b0;
    end
  endtask

  task automatic chk_data(input string tag, input int seed,
                          input int n, input int off);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (got_q[off + i] !== pay(seed, i)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic rej(input string tag, input logic [7:0] ver,
                     input logic [7:0] proto, input logic [15:0] frag,
                     input logic [31:0] dip, input logic [15:0] dport,
                     input logic [15:0] tot, input logic [15:0] ulen,
                     input logic [2:0] want);
    clr();
    build(ver, proto, frag, dip, dport, tot, ulen, 100, 128, 8'h00, 3);
    send(0, fr.size(), 0);
    idle(3);
    chk({tag, "_drops"}, n_drop, 1);
    chk({tag, "_reason"}, rsn, want);
    chk({tag, "_nout"}, got_q.size(), 0);
  endtask

  initial begin
    int flen;
    int npay;
    int seed;
    int bad;
    Rst = 1'b1;
    Mac_payload_data = 8'h00;
    Mac_payload_valid = 1'b0;
    Mac_payload_last = 1'b0;
    clr();
    repeat (3) @(negedge Clk);
    chk("rst_valid", Udp_valid, 0);
    chk("rst_last", Udp_last, 0);
    chk("rst_drop", Drop_valid, 0);
    chk("rst_srcip", Udp_src_ip, 0);
    chk("rst_len", Udp_length, 0);
    Rst = 1'b0;
    idle(2);

    // Valid datagram, 100 payload bytes
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 100, 128, 8'h00, 1);
    send(0, fr.size(), 0);
    idle(3);
    chk("v_nout", got_q.size(), 100);
    chk_data("v_data", 1, 100, 0);
    chk("v_nlast", last_pos.size(), 1);
    chk("v_lastpos", last_pos[0], 100);
    chk("v_err", n_err, 0);
    chk("v_drop", n_drop, 0);
    chk("v_len", Udp_length, 100);
    chk("v_srcip", Udp_src_ip, 32'hC0A8010A);
    chk("v_srcport", Udp_src_port, 16'h1234);

    // Short padded datagram followed back-to-back by a full one
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd32, 16'd12, 4, 46, 8'h00, 7);
    send(0, fr.size(), 0);
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 100, 128, 8'h00, 2);
    send(0, fr.size(), 0);
    idle(3);
    chk("s_nout", got_q.size(), 104);
    chk_data("s_data_a", 7, 4, 0);
    chk_data("s_data_b", 2, 100, 4);
    chk("s_nlast", last_pos.size(), 2);
    chk("s_lastpos_a", last_pos[0], 4);
    chk("s_lastpos_b", last_pos[1], 104);
    chk("s_drop", n_drop, 0);

    // Corrupted header checksum
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 100, 128, 8'h01, 4);
    send(0, fr.size(), 0);
    idle(3);
`ifdef UDP_RX_CHECKSUM_CHECK_EN
    chk("cs_drops", n_drop, 1);
    chk("cs_reason", rsn, 3);
    chk("cs_nout", got_q.size(), 0);
`else
    chk("cs_drops", n_drop, 0);
    chk("cs_nout", got_q.size(), 100);
`endif

    rej("ver", 8'h46, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
        16'd128, 16'd108, 3'd1);
    rej("proto", 8'h45, 8'd6, 16'h0, 32'h0A000002, 16'd5000,
        16'd128, 16'd108, 3'd2);
    rej("frag", 8'h45, 8'd17, 16'h0001, 32'h0A000002, 16'd5000,
        16'd128, 16'd108, 3'd4);
    rej("mf", 8'h45, 8'd17, 16'h2000, 32'h0A000002, 16'd5000,
        16'd128, 16'd108, 3'd4);
    rej("dstip", 8'h45, 8'd17, 16'h0, 32'h0A000003, 16'd5000,
        16'd128, 16'd108, 3'd5);
    rej("port", 8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5001,
        16'd128, 16'd108, 3'd6);
    rej("ulen_big", 8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
        16'd128, 16'd109, 3'd7);
    rej("ulen_8", 8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
        16'd128, 16'd8, 3'd7);

    // Truncated payload: 50 of 200 bytes
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd228, 16'd208, 50, 78, 8'h00, 11);
    send(0, fr.size(), 0);
    idle(3);
    chk("t_nout", got_q.size(), 50);
    chk_data("t_data", 11, 50, 0);
    chk("t_lastpos", last_pos.size() == 1 ? last_pos[0] : -1, 50);
    chk("t_err", n_err, 1);
    chk("t_len", Udp_length, 200);
    chk("t_drop", n_drop, 0);

    // Frame ends inside the IP header
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 0, 0, 8'h00, 0);
    fr = fr[0:15];
    send(0, fr.size(), 0);
    idle(3);
    chk("h15_drops", n_drop, 1);
    chk("h15_reason", rsn, 7);
    chk("h15_nout", got_q.size(), 0);

    // Reset in the middle of a payload
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 100, 128, 8'h00, 5);
    send(0, 58, 0);
    @(negedge Clk);
    Mac_payload_valid = 1'b0;
    Mac_payload_last = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("r_valid", Udp_valid, 0);
    clr();
    send(58, fr.size(), 0);
    idle(3);
    chk("r_nout", got_q.size(), 0);
    chk("r_drops", n_drop, 1);
    chk("r_reason", rsn, 1);
    clr();
    build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
          16'd128, 16'd108, 100, 128, 8'h00, 9);
    send(0, fr.size(), 0);
    idle(3);
    chk("r2_nout", got_q.size(), 100);
    chk_data("r2_data", 9, 100, 0);

    // Random back-to-back frames with idle gaps
    clr();
    exp_q.delete();
    for (int f = 0; f < 30; f++) begin
      npay = $urandom_range(1400, 1);
      seed = $urandom_range(255);
      flen = (npay + 28 < 46) ? 46 : npay + 28;
      build(8'h45, 8'd17, 16'h0, 32'h0A000002, 16'd5000,
            16'(npay + 28), 16'(npay + 8), npay, flen, 8'h00, seed);
      for (int i = 0; i < npay; i++) exp_q.push_back(pay(seed, i));
      send(0, fr.size(), 20);
    end
    idle(4);
    chk("rnd_nout", got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk("rnd_data", bad, 0);
    chk("rnd_nlast", last_pos.size(), 30);
    chk("rnd_err", n_err, 0);
    chk("rnd_drop", n_drop, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
